alineador_serial_paralelo: RTL and testbench

Receive-side front end for the PCIE interface; mirror of the transmit path's serializer stage. Takes the 1-bit serial stream at bit rate (clk) and finds 10-bit symbol boundaries using K28.5 comma detection. Outputs aligned 10-bit symbols, one per 10 bit-clocks, to the 8b/10b decoder. Tracks lock with a hunt/align/lock state machine.

---
 rtl/alineador_serial_paralelo_pkg.sv | 21 ++
 rtl/alineador_serial_paralelo_detector_coma.sv | 17 +
 rtl/alineador_serial_paralelo.sv | 201 ++++++++++++++++++++
 tb/tb_alineador_serial_paralelo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alineador_serial_paralelo_pkg.sv
// -----------------------------------------------------------------------------
// alineador_serial_paralelo_pkg
// Shared constants for the receive-side symbol aligner and the comma detector:
//   SYMBOL_W              width of one 8b/10b symbol
//   COMMA_NEG / COMMA_POS K28.5 in both running disparities
//   align_state_t         HUNT / ALIGN / LOCKED encodings (also the alignState port)
// -----------------------------------------------------------------------------
package alineador_serial_paralelo_pkg;

   localparam int SYMBOL_W = 10;

   localparam logic [SYMBOL_W-1:0] COMMA_NEG = 10'b0011111010;
   localparam logic [SYMBOL_W-1:0] COMMA_POS = 10'b1100000101;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'b00,
      ST_ALIGN  = 2'b01,
      ST_LOCKED = 2'b10
   } align_state_t;

endpackage

// File: rtl/alineador_serial_paralelo_detector_coma.sv
// -----------------------------------------------------------------------------
// detector_coma
// Purely combinational K28.5 detector; shared with the 8b/10b decoder for
// K-symbol flagging.
//   i_symbol [9:0]  candidate 10-bit window
//   o_comma         1 when i_symbol is K28.5 of either running disparity
// -----------------------------------------------------------------------------
module detector_coma
   import alineador_serial_paralelo_pkg::*;
(
   input  logic [SYMBOL_W-1:0] i_symbol,
   output logic                o_comma
);

   assign o_comma = (i_symbol == COMMA_NEG) || (i_symbol == COMMA_POS);

endmodule

// File: rtl/alineador_serial_paralelo.sv
// -----------------------------------------------------------------------------
// alineador_serial_paralelo
// Receive front end: shifts in the serial stream, finds 10-bit symbol
// boundaries with K28.5 commas and emits one aligned symbol per 10 bit-clocks.
// A HUNT / ALIGN / LOCKED machine tracks lock.
//   clk          bit-rate clock
//   rst          asynchronous active-low reset
//   enb          clock enable; when low everything holds, symbolValid is 0
//   serialIn     serial bit, bit 9 of each symbol first
//   symbolOut    last aligned symbol (registered)
//   symbolValid  one-cycle pulse when symbolOut is updated
//   isComma      symbolOut is a K28.5
//   locked       state is LOCKED
//   alignState   00 HUNT, 01 ALIGN, 10 LOCKED
//   lossCnt      (only with RX_ERRCNT_EN) saturating LOCKED->HUNT counter
// Optional feature macro: RX_ERRCNT_EN
// -----------------------------------------------------------------------------
module alineador_serial_paralelo
   import alineador_serial_paralelo_pkg::*;
#(
   parameter int LOCK_COMMAS = 3,
   parameter int LOSS_ERRS   = 4
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                enb,
   input  logic                serialIn,
   output logic [SYMBOL_W-1:0] symbolOut,
   output logic                symbolValid,
   output logic                isComma,
   output logic                locked,
   output logic [1:0]          alignState
`ifdef RX_ERRCNT_EN
   ,
   output logic [7:0]          lossCnt
`endif
);

   localparam int CW = $clog2(LOCK_COMMAS + 1);
   localparam int EW = $clog2(LOSS_ERRS + 1);

   logic [SYMBOL_W-1:0] r_shift;
   logic [3:0]          r_bit_cnt;
   logic [CW-1:0]       r_comma_cnt;
   logic [EW-1:0]       r_err_cnt;
   align_state_t        r_state;
   logic [SYMBOL_W-1:0] r_symbol;
   logic                r_valid;
   logic                r_is_comma;
   logic                r_locked;

   logic [SYMBOL_W-1:0] w_shift_next;
   logic                w_comma;
   logic                w_boundary;
   logic                w_emit;
   align_state_t        w_state_next;
   logic [3:0]          w_bit_next;
   logic [CW-1:0]       w_comma_next;
   logic [EW-1:0]       w_err_next;

   // The comma is judged on the window that includes the bit being sampled now.
   assign w_shift_next = {r_shift[SYMBOL_W-2:0], serialIn};
   assign w_boundary   = (r_bit_cnt == 4'd9);

   detector_coma u_detector_coma (
      .i_symbol (w_shift_next),
      .o_comma  (w_comma)
   );

   // Next-state, counter and emit decisions for the alignment machine.
   always_comb begin
      w_state_next = r_state;
      w_bit_next   = r_bit_cnt;
      w_comma_next = r_comma_cnt;
      w_err_next   = r_err_cnt;
      w_emit       = 1'b0;
      case (r_state)
         ST_HUNT: begin
            w_bit_next = 4'd0;
            if (w_comma) begin
               // The comma itself is the first aligned symbol.
               w_emit       = 1'b1;
               w_comma_next = CW'(1);
               w_err_next   = EW'(0);
               w_state_next = (LOCK_COMMAS == 1) ? ST_LOCKED : ST_ALIGN;
            end else begin
               w_emit = 1'b0;
            end
         end
         ST_ALIGN: begin
            if (w_boundary) begin
               w_emit     = 1'b1;
               w_bit_next = 4'd0;
               if (w_comma) begin
                  if (r_comma_cnt == CW'(LOCK_COMMAS - 1)) begin
                     w_comma_next = CW'(LOCK_COMMAS);
                     w_err_next   = EW'(0);
                     w_state_next = ST_LOCKED;
                  end else begin
                     w_comma_next = r_comma_cnt + CW'(1);
                  end
               end else begin
                  w_comma_next = r_comma_cnt;
               end
            end else if (w_comma) begin
               // A comma off the candidate boundary means the guess was wrong.
               w_bit_next   = 4'd0;
               w_comma_next = CW'(0);
               w_state_next = ST_HUNT;
            end else begin
               w_bit_next = r_bit_cnt + 4'd1;
            end
         end
         ST_LOCKED: begin
            if (w_boundary) begin
               w_emit     = 1'b1;
               w_bit_next = 4'd0;
               if (w_comma) begin
                  w_err_next = EW'(0);
               end else begin
                  w_err_next = r_err_cnt;
               end
            end else if (w_comma) begin
               // Tolerate stray commas until LOSS_ERRS of them accumulate.
               if (r_err_cnt == EW'(LOSS_ERRS - 1)) begin
                  w_bit_next   = 4'd0;
                  w_comma_next = CW'(0);
                  w_err_next   = EW'(0);
                  w_state_next = ST_HUNT;
               end else begin
                  w_bit_next = r_bit_cnt + 4'd1;
                  w_err_next = r_err_cnt + EW'(1);
               end
            end else begin
               w_bit_next = r_bit_cnt + 4'd1;
            end
         end
         default: begin
            w_bit_next   = 4'd0;
            w_comma_next = CW'(0);
            w_err_next   = EW'(0);
            w_state_next = ST_HUNT;
         end
      endcase
   end

   // State, shift register and registered outputs; enb low freezes all of it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift     <= {SYMBOL_W{1'b0}};
         r_bit_cnt   <= 4'd0;
         r_comma_cnt <= CW'(0);
         r_err_cnt   <= EW'(0);
         r_state     <= ST_HUNT;
         r_symbol    <= {SYMBOL_W{1'b0}};
         r_valid     <= 1'b0;
         r_is_comma  <= 1'b0;
         r_locked    <= 1'b0;
      end else if (enb) begin
         r_shift     <= w_shift_next;
         r_bit_cnt   <= w_bit_next;
         r_comma_cnt <= w_comma_next;
         r_err_cnt   <= w_err_next;
         r_state     <= w_state_next;
         r_valid     <= w_emit;
         r_locked    <= (w_state_next == ST_LOCKED);
         if (w_emit) begin
            r_symbol   <= w_shift_next;
            r_is_comma <= w_comma;
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign symbolOut   = r_symbol;
   assign symbolValid = r_valid;
   assign isComma     = r_is_comma;
   assign locked      = r_locked;
   assign alignState  = r_state;

`ifdef RX_ERRCNT_EN
   logic [7:0] r_loss_cnt;
   logic       w_loss_evt;

   assign w_loss_evt = enb && (r_state == ST_LOCKED) && (w_state_next == ST_HUNT);

   // Saturating count of lock losses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_loss_cnt <= 8'd0;
      end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign lossCnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_alineador_serial_paralelo.sv
// -----------------------------------------------------------------------------
// tb_alineador_serial_paralelo
// Directed stimulus; expected symbols go into a queue when stimulus is issued
// and a negedge monitor pops/compares them on every symbolValid pulse.
// Build with RX_ERRCNT_EN defined to also exercise lossCnt.
// -----------------------------------------------------------------------------
module tb_alineador_serial_paralelo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enb = 1'b0;
   logic       serialIn = 1'b0;
   logic [9:0] symbolOut;
   logic       symbolValid;
   logic       isComma;
   logic       locked;
   logic [1:0] alignState;
`ifdef RX_ERRCNT_EN
   logic [7:0] lossCnt;
`endif

   alineador_serial_paralelo #(.LOCK_COMMAS(3), .LOSS_ERRS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .enb         (enb),
      .serialIn    (serialIn),
      .symbolOut   (symbolOut),
      .symbolValid (symbolValid),
      .isComma     (isComma),
      .locked      (locked),
      .alignState  (alignState)
`ifdef RX_ERRCNT_EN
      ,
      .lossCnt     (lossCnt)
`endif
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mon_exp;

   // 5 data bits, a comma straddling the symbol boundary, 5 data bits:
   // aligned symbols are 0x2A7 and 0x355, neither a comma.
   localparam logic [19:0] XV = 20'b10101_0011111010_10101;
   localparam logic [9:0]  K_NEG = 10'h0FA;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic push(input logic [9:0] s, input logic c);
      exp_q.push_back({s, c});
   endtask

   task automatic send_bit(input logic b);
      serialIn = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_vec(input logic [19:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && symbolValid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: got %h/%b want none", symbolOut, isComma);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({symbolOut, isComma} !== mon_exp) begin
               n_bad++;
               $display("FAIL symbol: got %h/%b want %h/%b",
                        symbolOut, isComma, mon_exp[10:1], mon_exp[0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [9:0] sym;
      @(posedge clk);
      #1;
      chk("rst_symbolOut", 16'(symbolOut), 16'h000);
      chk("rst_valid", 16'(symbolValid), 16'h0);
      chk("rst_isComma", 16'(isComma), 16'h0);
      chk("rst_locked", 16'(locked), 16'h0);
      chk("rst_state", 16'(alignState), 16'h0);
`ifdef RX_ERRCNT_EN
      chk("rst_lossCnt", 16'(lossCnt), 16'h0);
`endif
      rst = 1'b1;
      enb = 1'b1;

      // Acquisition: 7 junk bits then three commas.
      send_vec(20'b1010011, 7);
      push(K_NEG, 1'b1);
      send_vec(20'(K_NEG), 10);
      chk("acq_latency_valid", 16'(symbolValid), 16'h1);
      chk("acq_state_align", 16'(alignState), 16'h1);
      push(K_NEG, 1'b1);
      send_vec(20'(K_NEG), 10);
      chk("acq_state_align2", 16'(alignState), 16'h1);
      chk("acq_locked_low", 16'(locked), 16'h0);
      push(K_NEG, 1'b1);
      send_vec(20'(K_NEG), 10);
      chk("acq_state_locked", 16'(alignState), 16'h2);
      chk("acq_locked", 16'(locked), 16'h1);
      push(10'h0F0, 1'b0);
      send_vec(20'h0F0, 10);

      // Three stray commas, then an aligned comma clears the error count.
      for (int i = 0; i < 3; i++) begin
         push(10'h2A7, 1'b0);
         push(10'h355, 1'b0);
         send_vec(XV, 20);
      end
      chk("tol3_locked", 16'(locked), 16'h1);
      push(K_NEG, 1'b1);
      send_vec(20'(K_NEG), 10);
      for (int i = 0; i < 3; i++) begin
         push(10'h2A7, 1'b0);
         push(10'h355, 1'b0);
         send_vec(XV, 20);
         chk("errclr_locked", 16'(locked), 16'h1);
      end
      // Fourth stray comma drops lock on the comma's edge.
      push(10'h2A7, 1'b0);
      send_vec(XV >> 5, 15);
      chk("loss_locked", 16'(locked), 16'h0);
      chk("loss_state", 16'(alignState), 16'h0);
      chk("loss_valid", 16'(symbolValid), 16'h0);
`ifdef RX_ERRCNT_EN
      chk("loss_lossCnt", 16'(lossCnt), 16'h1);
`endif
      send_vec(XV, 5);

      // ALIGN abort: aligned comma, then a comma 4 bits off boundary.
      push(K_NEG, 1'b1);
      send_vec(20'(K_NEG), 10);
      chk("abort_pre_state", 16'(alignState), 16'h1);
      push(10'h28F, 1'b0);
      send_vec(20'b1010_0011111010, 14);
      chk("abort_state", 16'(alignState), 16'h0);
      chk("abort_valid", 16'(symbolValid), 16'h0);

      // Re-acquire with a 3-bit slip.
      send_vec(20'b101, 3);
      for (int i = 0; i < 3; i++) begin
         push(K_NEG, 1'b1);
         send_vec(20'(K_NEG), 10);
      end
      chk("slip_locked", 16'(locked), 16'h1);
      push(10'h2AA, 1'b0);
      send_vec(20'h2AA, 10);

      // enb gating mid-symbol.
      sym = 10'h133;
      push(sym, 1'b0);
      send_vec(20'(sym) >> 7, 3);
      enb = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_bit(i[0]);
         chk("gate_valid", 16'(symbolValid), 16'h0);
      end
      chk("gate_state", 16'(alignState), 16'h2);
      enb = 1'b1;
      send_vec(20'(sym) >> 1, 6);
      chk("gate_valid_early", 16'(symbolValid), 16'h0);
      send_bit(sym[0]);
      chk("gate_valid_on_time", 16'(symbolValid), 16'h1);
      push(10'h2AA, 1'b0);
      send_vec(20'h2AA, 10);

      // Reset mid-symbol.
      send_vec(20'b1011, 4);
      #2;
      rst = 1'b0;
      #1;
      chk("mrst_symbolOut", 16'(symbolOut), 16'h000);
      chk("mrst_isComma", 16'(isComma), 16'h0);
      chk("mrst_locked", 16'(locked), 16'h0);
      chk("mrst_state", 16'(alignState), 16'h0);
`ifdef RX_ERRCNT_EN
      chk("mrst_lossCnt", 16'(lossCnt), 16'h0);
`endif
      @(posedge clk);
      #1;
      chk("mrst_valid", 16'(symbolValid), 16'h0);
      rst = 1'b1;
      send_vec(20'h2AA, 10);
      chk("post_rst_state", 16'(alignState), 16'h0);

      #10;
      chk("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
